rsa_modexp: RTL and testbench

//  Sequential modular exponentiator: result = msg^key mod modulus. Sits downstream of the key

---
 rtl/rsa_modexp_pkg.sv | 17 +
 rtl/rsa_modexp_if.sv | 28 ++
 rtl/rsa_modexp_modmul_serial.sv | 78 +++++++
 rtl/rsa_modexp.sv | 162 ++++++++++++++++
 tb/tb_rsa_modexp.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rsa_modexp_pkg.sv
// Shared definitions for the modular exponentiator: FSM state encoding and
// the default prime width (operands are 2*WIDTH bits wide).
package rsa_modexp_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RED  = 3'd2,
    STEP = 3'd3,
    MUL  = 3'd4,
    SQR  = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/rsa_modexp_if.sv
// Request/response bundle of the modular exponentiator. The master side
// issues start with msg/key/modulus and watches busy/done/err/result.
interface rsa_modexp_if
  import rsa_modexp_pkg::*;
#(
  parameter int N = 2 * DEFAULT_WIDTH
);

  logic         start;
  logic [N-1:0] msg;
  logic [N-1:0] key;
  logic [N-1:0] modulus;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] result;

  modport master (
    output start, msg, key, modulus,
    input  busy, done, err, result
  );

  modport slave (
    input  start, msg, key, modulus,
    output busy, done, err, result
  );

endinterface

// File: rtl/rsa_modexp_modmul_serial.sv
// Bit-serial interleaved modular multiplier: r = a*b mod n, b scanned MSB
// first. The first step is taken on the go edge straight from the ports, so
// the product is ready (done pulse) exactly N cycles after go is sampled.
// Requires a < n; b may take any value.
module modmul_serial #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         go,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] n,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] r
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  a_q;
  logic [N-1:0]  n_q;
  logic [N-1:0]  b_sh;
  logic [CW-1:0] cnt;

  // One interleaved step: t = 2*r + bit*a on N+2 bits, then two conditional
  // subtractions bring it back below n (t < 3n because r < n and a < n).
  // NOTE: blocking assignments are correct here: t is a local temporary
  // evaluated in order inside a function, not a clocked register.
  function automatic logic [N-1:0] mm_step(input logic [N-1:0] r_in,
                                           input logic         bit_in,
                                           input logic [N-1:0] a_in,
                                           input logic [N-1:0] n_in);
    logic [N+1:0] t;
    logic [N+1:0] n_ext;
    n_ext = {2'b00, n_in};
    t = {1'b0, r_in, 1'b0} + (bit_in ? {2'b00, a_in} : '0);
    if (t >= n_ext) t = t - n_ext;
    if (t >= n_ext) t = t - n_ext;
    return t[N-1:0];
  endfunction

  // Step sequencer: latch operands on go, then walk the remaining b bits.
  // NOTE: every register is reset, including the datapath, so an aborted
  // multiply leaves no stale product or half-shifted operand behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      n_q  <= '0;
      b_sh <= '0;
      cnt  <= '0;
      r    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // updates from the pre-edge values, independent of statement order.
      done <= 1'b0;
      if (busy) begin
        r    <= mm_step(r, b_sh[N-1], a_q, n_q);
        b_sh <= {b_sh[N-2:0], 1'b0};
        cnt  <= cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (go) begin
        r    <= mm_step('0, b[N-1], a, n);
        a_q  <= a;
        n_q  <= n;
        b_sh <= {b[N-2:0], 1'b0};
        cnt  <= CW'(1);
        busy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// Sequential modular exponentiator: result = msg^key mod modulus, using
// right-to-left square-and-multiply over the bit-serial multiplier.
// Optional build macro RSA_MODEXP_EARLY_EXIT_EN: stop as soon as the
// remaining key bits are all zero (same result, key-dependent latency).
// Without it all N key bits are always processed.
module rsa_modexp
  import rsa_modexp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  rsa_modexp_if.slave  bus
);

  localparam int N  = 2 * WIDTH;
  localparam int BW = $clog2(N);

  state_t        state;
  logic [N-1:0]  msg_q;
  logic [N-1:0]  key_sh;
  logic [N-1:0]  mod_q;
  logic [N-1:0]  acc;
  logic [N-1:0]  base;
  logic [BW-1:0] bitcnt;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [N-1:0]  result_q;

  logic          mm_go;
  logic [N-1:0]  mm_a;
  logic [N-1:0]  mm_b;
  logic [N-1:0]  mm_r;
  logic          mm_busy;
  logic          mm_done;
  logic          mm_finish;

  // A fresh product is ready and the multiplier is back to idle.
  assign mm_finish = mm_done & ~mm_busy;

  // Operand routing: the multiplier samples these on the first cycle of
  // RED (acc*msg), MUL (acc*base) and SQR (base*base).
  // NOTE: defaults first so every path assigns both outputs and no latch
  // is inferred.
  always_comb begin
    mm_a = acc;
    mm_b = base;
    case (state)
      RED:     mm_b = msg_q;
      SQR:     mm_a = base;
      default: ;
    endcase
  end

  modmul_serial #(.N(N)) u_modmul (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (mm_go),
    .a       (mm_a),
    .b       (mm_b),
    .n       (mod_q),
    .busy    (mm_busy),
    .done    (mm_done),
    .r       (mm_r)
  );

  // Exponentiation FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      msg_q    <= '0;
      key_sh   <= '0;
      mod_q    <= '0;
      acc      <= '0;
      base     <= '0;
      bitcnt   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      mm_go    <= 1'b0;
    end else begin
      mm_go  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays up through the done cycle and falls one cycle later
          busy_q <= 1'b0;
          if (bus.start) begin
            msg_q  <= bus.msg;
            key_sh <= bus.key;
            mod_q  <= bus.modulus;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= INIT;
          end
        end
        INIT: begin
          if (mod_q == '0) begin
            acc   <= '0;
            state <= DONE;
          end else begin
            // 1 mod n is 0 when n == 1
            acc   <= (mod_q == N'(1)) ? '0 : N'(1);
            mm_go <= 1'b1;
            state <= RED;
          end
        end
        RED: begin
          if (mm_finish) begin
            base   <= mm_r;
            bitcnt <= '0;
            state  <= STEP;
          end
        end
        STEP: begin
          mm_go <= 1'b1;
          state <= key_sh[0] ? MUL : SQR;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
          if (key_sh == '0) begin
            mm_go <= 1'b0;
            state <= DONE;
          end
`endif
        end
        MUL: begin
          if (mm_finish) begin
            acc   <= mm_r;
            mm_go <= 1'b1;
            state <= SQR;
          end
        end
        SQR: begin
          if (mm_finish) begin
            base   <= mm_r;
            key_sh <= key_sh >> 1;
            if (bitcnt == BW'(N - 1)) begin
              state <= DONE;
            end else begin
              bitcnt <= bitcnt + BW'(1);
              state  <= STEP;
            end
          end
        end
        DONE: begin
          result_q <= acc;
          err_q    <= (mod_q == '0);
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp at WIDTH=8 (16-bit operands).
// Expected results come from a left-to-right exponentiation model on plain
// integers; expected latency comes from the closed-form cycle count.
module tb_rsa_modexp;

  localparam int WIDTH = 8;
  localparam int N     = 2 * WIDTH;
  localparam int LIMIT = 2000;

  typedef struct {
    logic [N-1:0] result;
    logic         err;
    int           lat;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_fail;
  exp_t exp_q[$];

  rsa_modexp_if #(.N(N)) bus ();

  rsa_modexp #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // msg^key mod n, scanning the exponent from the top bit down.
  function automatic logic [N-1:0] ref_modexp(input logic [N-1:0] m,
                                              input logic [N-1:0] k,
                                              input logic [N-1:0] n);
    longint unsigned r, b, nn;
    if (n == '0) return '0;
    nn = longint'(n);
    b  = longint'(m) % nn;
    r  = 1 % nn;
    for (int i = N - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (k[i]) r = (r * b) % nn;
    end
    return N'(r);
  endfunction

  // Busy cycles from accept to done inclusive.
  function automatic int lat_model(input logic [N-1:0] k, input logic [N-1:0] n);
    int h;
    if (n == '0) return 3;
    h = $countones(k);
`ifdef RSA_MODEXP_EARLY_EXIT_EN
    begin
      int nb;
      nb = 0;
      for (int i = 0; i < N; i++) if (k[i]) nb = i + 1;
      if (nb < N) return N + 5 + nb * (N + 2) + h * (N + 1);
    end
`endif
    return 3 + (N + 1) + N * (2 + N) + h * (N + 1);
  endfunction

  // Compare process: every done is matched against the oldest request.
  int  busy_cnt;
  bit  done_prev;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (bus.busy) busy_cnt++;
      else busy_cnt = 0;
      if (bus.done) begin
        check("done_width", done_prev, 0);
        check("pending_request", exp_q.size() != 0, 1);
        check("busy_at_done", bus.busy, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", bus.result, e.result);
          check("err", bus.err, e.err);
          check("latency", busy_cnt, e.lat);
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic run(input logic [N-1:0] m, input logic [N-1:0] k,
                     input logic [N-1:0] n, input int exp_lit, input bit poke);
    exp_t e;
    int   waited;
    e.result = ref_modexp(m, k, n);
    e.err    = (n == '0);
    e.lat    = lat_model(k, n);
    if (exp_lit >= 0) check("model_pin", e.result, exp_lit);
    exp_q.push_back(e);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.msg     = m;
    bus.key     = k;
    bus.modulus = n;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.msg     = N'($urandom);
    bus.key     = N'($urandom);
    bus.modulus = N'($urandom);
    check("err_clear_on_accept", bus.err, 0);
    check("busy_after_accept", bus.busy, 1);
    if (poke) begin
      repeat (30) @(negedge clk);
      bus.start = 1'b1;
      bus.msg   = 16'd1234;
      bus.key   = 16'd3;
      @(negedge clk);
      bus.start = 1'b0;
    end
    waited = 0;
    while (!bus.done && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    check("done_timeout", waited < LIMIT, 1);
    if (waited >= LIMIT) exp_q.delete();
    @(negedge clk);
    check("busy_drop", bus.busy, 0);
    check("done_drop", bus.done, 0);
  endtask

  initial begin
    logic [N-1:0] rm, rk, rn;
    n_vec       = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.msg     = '0;
    bus.key     = '0;
    bus.modulus = '0;
    #12;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_result", bus.result, 0);
`ifdef RSA_MODEXP_EARLY_EXIT_EN
    check("lat_model_pin", lat_model(16'd17, 16'd3233), 145);
`else
    check("lat_model_pin", lat_model(16'd17, 16'd3233), 342);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    run(16'd65,   16'd17,   16'd3233, 2790, 1'b0);
    run(16'd2790, 16'd2753, 16'd3233, 65,   1'b0);
    run(16'd4000, 16'd1,    16'd3233, 767,  1'b0);
    run(16'd123,  16'd0,    16'd3233, 1,    1'b0);
    run(16'd777,  16'd5,    16'd1,    0,    1'b0);
    run(16'd0,    16'd9,    16'd3233, 0,    1'b0);
    run(16'd5,    16'd7,    16'd0,    0,    1'b0);
    run(16'd65,   16'd17,   16'd3233, 2790, 1'b0);
    run(16'd2,    16'hFFFF, 16'd65521, -1,  1'b0);
    run(16'hFFFE, 16'h8001, 16'hFFFF, -1,   1'b0);
    run(16'd65,   16'd17,   16'd3233, 2790, 1'b1);

    // Abort in the middle of a squaring, then make sure the next job is clean.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.msg     = 16'd65;
    bus.key     = 16'd2;
    bus.modulus = 16'd3233;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (N + 8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run(16'd2790, 16'd2753, 16'd3233, 65, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rn = N'($urandom_range(2, 65535));
      rm = N'($urandom);
      rk = N'($urandom);
      if (i % 3 == 0) rk = rk & 16'h00FF;
      run(rm, rk, rn, -1, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
